uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver for the inter-board PONG link.
- Consumes the line driven by the TxD transmitter: 8N1, LSB first, idle-high.
- Recovers each byte, presents it on data_out and flags it with a one-cycle data_valid pulse.
- Downstream game logic latches data_out on data_valid.
- Same clock domain and bit timing as TxD: 100 MHz, 9600 baud.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per bit period. Must be ≥ 4. HALF = CLKS_PER_BIT/2, integer division.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-low reset.
- RxD  input  1  serial line, asynchronous to clk, idle high.
- data_out  output  8  last correctly received byte. Held until the next good frame.
- data_valid  output  1  one-cycle pulse. data_out is updated in that same cycle.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; data_out=8'h00; data_valid=0; frame_err=0; busy=0; bit counter=0; baud counter=0; both sync flops=1.
- Synchroniser: RxD passes through 2 flip-flops before any use. rx_s denotes the synchronised line.
- Baud counter: counts 0..limit-1, then clears to 0 and fires an internal tick. Limit is HALF in START, CLKS_PER_BIT elsewhere. Counter is cleared on every state change.
- IDLE: when rx_s==0, go to START.
- START: on tick, at mid start bit, sample rx_s.
  - rx_s==0 → DATA, bit counter=0.
  - rx_s==1 → glitch; back to IDLE, no output.
- DATA: on each tick, shift rx_s into bit[bit counter], LSB first, then bit counter+1. After bit 7 is sampled, go to STOP.
- STOP: on tick, sample rx_s.
  - rx_s==1 → data_out<=shift register, data_valid=1 for that one cycle, go to IDLE.
  - rx_s==0 → frame_err=1 for one cycle, data_out unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. This stops a stuck-low line from re-triggering.
- Latency: data_valid rises 2 + HALF + 9*CLKS_PER_BIT cycles after the RxD falling edge of the start bit. For the default this is 98954 cycles; the bench checks ±2.
- Back-to-back frames: STOP returns to IDLE at mid stop bit, so a start bit that immediately follows the stop bit is caught with no lost frame.
- data_valid and frame_err are never high in the same cycle. Neither is ever high for more than 1 cycle.
- RxD changing between samples is ignored. Each bit is sampled exactly once, at its midpoint. There is no majority vote.
- Reset mid-frame: all state is discarded at once. The partial byte is never presented. The first frame after reset is received normally.

Test Plan:
- Loopback with existing TxD, data=8'hEF, transmit_btn pulsed. Expect: data_out==8'hEF; exactly one data_valid pulse 98954±2 cycles after the TxD falling edge; frame_err stays 0; busy returns to 0.
- Glitch rejection: RxD low for 3000 cycles (< HALF=5208), then high. Expect: busy goes high then returns to 0 at the start sample; no data_valid; no frame_err; data_out unchanged.
- Framing error: drive start, data 8'h55, stop bit 0, line held low 2 bit times, then high. Expect: frame_err pulses once; data_valid never; data_out keeps its previous value; busy stays 1 until the line returns high.
- Back-to-back: CLKS_PER_BIT=16, drive 8'h00 then 8'hFF, then 8'hA5, with zero idle between frames. Expect: three data_valid pulses with data_out 8'h00, 8'hFF, 8'hA5 in order; no frame_err.
- Reset mid-frame: CLKS_PER_BIT=16; rst low during data bit 4 of 8'h3C, release, then send 8'hC3. Expect: outputs at reset values immediately on rst low; no pulse for 8'h3C; data_valid with data_out==8'hC3.
- Reset values: hold rst low with RxD toggling. Expect: data_out==8'h00, data_valid==0, frame_err==0, busy==0 throughout.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver, LSB first, mid-bit sampling
module uart_rx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state;
    logic          sync1;
    logic          rx_s;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] limit;
    logic          tick;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;

    // Half-bit period in START lands every later sample at a bit midpoint
    assign limit = (state == START) ? CW'(HALF) : CW'(CLKS_PER_BIT);
    assign tick  = (baud_cnt == limit - CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sync1      <= 1'b1;
            rx_s       <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sync1      <= RxD;
            rx_s       <= sync1;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            baud_cnt   <= tick ? '0 : baud_cnt + CW'(1);

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift[bit_cnt] <= rx_s;
                        bit_cnt        <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so an immediately following start edge is seen
                    if (tick) begin
                        if (rx_s) begin
                            data_out   <= shift;
                            data_valid <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    baud_cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized scoreboard bench for uart_rx
module tb_uart_rx;
    localparam int C    = 16;
    localparam int HALF = C / 2;
    localparam int LAT  = 2 + HALF + 9 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        int         t_fall;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic       prev_dv = 1'b0;
    logic       prev_fe = 1'b0;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .RxD        (RxD),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per pulse
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (data_valid || frame_err) begin
            check("pulse_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual dv=%0b fe=%0b required=none", data_valid, frame_err);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, frame_err}, {31'd0, e.ferr});
                if (!e.ferr) begin
                    check("data_out", {24'd0, data_out}, {24'd0, e.data});
                    lat = cyc - e.t_fall;
                    checks++;
                    if (lat < LAT - 2 || lat > LAT + 2) begin
                        failures++;
                        $display("FAIL latency actual=%0d required=%0d+-2", lat, LAT);
                    end
                    last_good = e.data;
                end else begin
                    check("data_hold", {24'd0, data_out}, {24'd0, last_good});
                end
            end
        end
        if (prev_dv && data_valid) check("dv_width", 32'd2, 32'd1);
        if (prev_fe && frame_err) check("fe_width", 32'd2, 32'd1);
        prev_dv <= data_valid;
        prev_fe <= frame_err;
    end

    task automatic hold(input logic b, input int n);
        RxD = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit good);
        exp_t e;
        e.ferr   = !good;
        e.data   = d;
        e.t_fall = cyc;
        exp_q.push_back(e);
        hold(1'b0, C);
        for (int i = 0; i < 8; i++) hold(d[i], C);
        if (good) begin
            hold(1'b1, C);
            check("busy_after_frame", {31'd0, busy}, 32'd0);
        end else begin
            hold(1'b0, 2 * C);
            check("busy_while_low", {31'd0, busy}, 32'd1);
            hold(1'b1, C);
            check("busy_after_ferr", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic glitch(input int len);
        hold(1'b0, len);
        check("busy_glitch_high", {31'd0, busy}, 32'd1);
        hold(1'b1, C);
        check("busy_glitch_idle", {31'd0, busy}, 32'd0);
        check("data_glitch_hold", {24'd0, data_out}, {24'd0, last_good});
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {21'd0, data_out, data_valid, frame_err, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        int         r;
        // Reset held with the line toggling
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            RxD = 1'(i % 2);
            @(posedge clk);
            #1;
            check_reset_outputs("reset_values");
        end
        RxD = 1'b1;
        rst = 1'b1;
        hold(1'b1, C);

        send(8'hEF, 1'b1);
        glitch(HALF - 3);
        send(8'h55, 1'b0);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'hA5, 1'b1);
        hold(1'b1, C);

        // Reset in the middle of data bit 4 of 8'h3C
        d = 8'h3C;
        hold(1'b0, C);
        for (int i = 0; i < 4; i++) hold(d[i], C);
        RxD = d[4];
        repeat (HALF) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_midframe");
        last_good = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        RxD = 1'b1;
        rst = 1'b1;
        hold(1'b1, C);
        send(8'hC3, 1'b1);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                send(8'($urandom_range(0, 255)), 1'b1);
                r = $urandom_range(0, 2);
                if (r > 0) hold(1'b1, r * C);
            end else if (r < 8) begin
                send(8'($urandom_range(0, 255)), 1'b0);
            end else begin
                glitch($urandom_range(3, HALF - 3));
            end
        end

        for (int i = 0; i < 20 * C && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
